// File: rtl/dht11_ctrl.sv
// rtl/dht11_ctrl.sv - DHT11 single-wire protocol engine with checksum validation

module dht11_ctrl #(
    parameter int US_DIV        = 100,
    parameter int START_LOW_US  = 18000,
    parameter int BIT_THRESH_US = 40,
    parameter int TIMEOUT_US    = 200,
    parameter int PERIOD_MS     = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    inout  wire        dht_signal,
    output logic [7:0] hum_high,
    output logic [7:0] hum_low,
    output logic [7:0] tem_high,
    output logic [7:0] tem_low,
    output logic [7:0] checksum,
    output logic       state_done,
    output logic       chk_err,
    output logic       busy
);

    localparam int US_MAX0 = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int US_MAX  = (US_MAX0 > BIT_THRESH_US) ? US_MAX0 : BIT_THRESH_US;
    localparam int US_W    = $clog2(US_MAX + 1);
    localparam int DIV_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(US_DIV - 1);
    localparam logic [US_W-1:0]  START_LAST   = US_W'(START_LOW_US - 1);
    localparam logic [US_W-1:0]  TIMEOUT_LAST = US_W'(TIMEOUT_US - 1);
    localparam logic [US_W-1:0]  THRESH       = US_W'(BIT_THRESH_US);

    localparam longint PERIOD_CYC = longint'(PERIOD_MS) * 1000 * longint'(US_DIV);
    localparam int     PER_W      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);
    localparam bit     AUTO_EN    = (PERIOD_MS != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RELEASE,
        S_RESP_L,
        S_RESP_H,
        S_BIT_L,
        S_BIT_H,
        S_CHECK
    } state_t;

    state_t state, state_next;

    logic             sync1, sync2, sync3;
    logic             rise, fall;
    logic [DIV_W-1:0] div_cnt;
    logic [US_W-1:0]  us_cnt;
    logic             tick;
    logic             entering;
    logic             timeout;
    logic             wait_st;
    logic [PER_W-1:0] per_cnt;
    logic             per_hit;
    logic [5:0]       bit_cnt;
    logic [39:0]      shreg;
    logic [7:0]       sum_calc;

    // Synchronizer idles high so the released line never looks like an edge after reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= dht_signal;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise     = sync2 & ~sync3;
    assign fall     = ~sync2 & sync3;
    assign tick     = (div_cnt == DIV_LAST);
    assign entering = (state_next != state);
    assign per_hit  = AUTO_EN && (per_cnt == PER_LAST);
    assign wait_st  = state inside {S_RELEASE, S_RESP_L, S_RESP_H, S_BIT_L, S_BIT_H};
    assign sum_calc = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

    always_ff @(posedge clk) begin
        if (!rst || entering) begin
            div_cnt <= '0;
            us_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            us_cnt  <= us_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Holds at expiry so a trigger that lands while busy fires on return to IDLE
    always_ff @(posedge clk) begin
        if (!rst || (state_next == S_START && state != S_START)) begin
            per_cnt <= '0;
        end else if (per_cnt != PER_LAST) begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        case (state)
            S_IDLE:    if (start || per_hit) state_next = S_START;
            S_START:   if (tick && us_cnt == START_LAST) state_next = S_RELEASE;
            S_RELEASE: if (fall) state_next = S_RESP_L;
            S_RESP_L:  if (rise) state_next = S_RESP_H;
            S_RESP_H:  if (fall) state_next = S_BIT_L;
            S_BIT_L:   if (rise) state_next = S_BIT_H;
            S_BIT_H:   if (fall) state_next = (bit_cnt == 6'd39) ? S_CHECK : S_BIT_L;
            S_CHECK:   state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (wait_st && tick && us_cnt == TIMEOUT_LAST && state_next == state) begin
            state_next = S_IDLE;
            timeout    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hum_high   <= '0;
            hum_low    <= '0;
            tem_high   <= '0;
            tem_low    <= '0;
            checksum   <= '0;
            state_done <= 1'b0;
            chk_err    <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
        end else begin
            state_done <= 1'b0;
            chk_err    <= timeout;
            if (state == S_RESP_H && fall) begin
                bit_cnt <= '0;
            end
            // Fall is seen on the last cycle of the high pulse, so us_cnt >= THRESH
            // means the elapsed high time exceeded the threshold
            if (state == S_BIT_H && fall) begin
                shreg   <= {shreg[38:0], (us_cnt >= THRESH)};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == S_CHECK) begin
                if (sum_calc == shreg[7:0]) begin
                    hum_high   <= shreg[39:32];
                    hum_low    <= shreg[31:24];
                    tem_high   <= shreg[23:16];
                    tem_low    <= shreg[15:8];
                    checksum   <= shreg[7:0];
                    state_done <= 1'b1;
                end else begin
                    chk_err <= 1'b1;
                end
            end
        end
    end

    assign busy       = (state != S_IDLE);
    assign dht_signal = (state == S_START) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dht11_ctrl.sv
// tb/tb_dht11_ctrl.sv - randomized scoreboard bench for dht11_ctrl with a line-level sensor model

module tb_dht11_ctrl;

    localparam int D   = 2;
    localparam int THR = 40;
    localparam int TMO = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_auto, start, start_auto, sensor_low;
    wire  line, line_auto;

    logic [7:0] hum_high, hum_low, tem_high, tem_low, checksum;
    logic       state_done, chk_err, busy;
    logic [7:0] a_hh, a_hl, a_th, a_tl, a_cs;
    logic       a_done, a_err, a_busy;

    assign line = sensor_low ? 1'b0 : 1'bz;
    pullup (line);
    pullup (line_auto);

    dht11_ctrl #(
        .US_DIV(2), .START_LOW_US(20), .BIT_THRESH_US(40), .TIMEOUT_US(200), .PERIOD_MS(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dht_signal(line),
        .hum_high(hum_high), .hum_low(hum_low), .tem_high(tem_high), .tem_low(tem_low),
        .checksum(checksum), .state_done(state_done), .chk_err(chk_err), .busy(busy)
    );

    dht11_ctrl #(
        .US_DIV(2), .START_LOW_US(20), .BIT_THRESH_US(40), .TIMEOUT_US(200), .PERIOD_MS(1)
    ) dut_auto (
        .clk(clk), .rst(rst_auto), .start(start_auto), .dht_signal(line_auto),
        .hum_high(a_hh), .hum_low(a_hl), .tem_high(a_th), .tem_low(a_tl),
        .checksum(a_cs), .state_done(a_done), .chk_err(a_err), .busy(a_busy)
    );

    typedef struct {
        logic        err;
        logic [39:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [39:0] exp_out = '0;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          ht[40];
    bit          mon_en = 0;
    bit          auto_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (state_done || chk_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", 64'({state_done, chk_err}), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", 64'({state_done, chk_err}), e.err ? 64'(1) : 64'(2));
                        if (!e.err && state_done) exp_out = e.data;
                        check("busy_at_event", 64'(busy), 64'(0));
                    end
                end
                check("outputs", 64'({hum_high, hum_low, tem_high, tem_low, checksum}), 64'(exp_out));
            end
        end
    end

    task automatic phase(input logic low, input int us);
        sensor_low = low;
        repeat (us * D) @(posedge clk);
        #1;
    endtask

    task automatic wait_line(input logic v, input int limit, output bit ok);
        int n = 0;
        while (line !== v && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = (line === v);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // mode 0: 26/70 us, mode 1: 40/41 us boundary, mode 2: random mix
    task automatic run_frame(input logic [39:0] f, input int mode, input int abort_bit);
        logic [39:0] rx;
        int          sum;
        bit          ok;
        for (int i = 0; i < 40; i++) begin
            if (mode == 0) ht[i] = f[39-i] ? 70 : 26;
            else if (mode == 1) ht[i] = f[39-i] ? 41 : 40;
            else begin
                case ($urandom_range(0, 2))
                    0:       ht[i] = f[39-i] ? 41 : 40;
                    1:       ht[i] = f[39-i] ? 70 : 26;
                    default: ht[i] = f[39-i] ? int'($urandom_range(41, 90)) : int'($urandom_range(8, 40));
                endcase
            end
            rx[39-i] = (ht[i] > THR);
        end
        sum = int'(rx[39:32]) + int'(rx[31:24]) + int'(rx[23:16]) + int'(rx[15:8]);
        if (abort_bit < 0) exp_q.push_back('{err: ((sum % 256) != int'(rx[7:0])), data: rx});
        pulse_start();
        wait_line(1'b0, 10, ok);
        check("host_start_low", 64'(ok), 64'(1));
        wait_line(1'b1, 100, ok);
        check("host_release", 64'(ok), 64'(1));
        phase(1'b0, 20);
        phase(1'b1, 30);
        phase(1'b0, 30);
        for (int i = 0; i < 40; i++) begin
            phase(1'b1, 10);
            if (i == abort_bit) begin
                sensor_low = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                return;
            end
            phase(1'b0, ht[i]);
        end
        phase(1'b1, 10);
        sensor_low = 1'b0;
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
        check("frame_event_seen", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin : auto_chk
        int   t[3];
        logic last;
        bit   seen;
        wait (rst_auto === 1'b1);
        for (int s = 0; s < 3; s++) begin
            seen = 0;
            last = line_auto;
            for (int k = 0; k < 3000 && !seen; k++) begin
                @(negedge clk);
                if (last === 1'b1 && line_auto === 1'b0) seen = 1;
                last = line_auto;
            end
            t[s] = cyc;
            check("auto_start_seen", 64'(seen), 64'(1));
            if (s == 0) begin
                repeat (100) @(posedge clk);
                #1;
                check("auto_busy", 64'(a_busy), 64'(1));
                start_auto = 1'b1;
                @(posedge clk);
                #1 start_auto = 1'b0;
            end
        end
        check("auto_period_1", 64'(t[1] - t[0]), 64'(2000));
        check("auto_period_2", 64'(t[2] - t[1]), 64'(2000));
        auto_done = 1;
    end

    initial begin : main
        logic [31:0] r;
        logic [7:0]  cs;
        int          n, m;
        rst = 1'b0;
        rst_auto = 1'b0;
        start = 1'b0;
        start_auto = 1'b0;
        sensor_low = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({hum_high, hum_low, tem_high, tem_low, checksum}), 64'(0));
        check("reset_pulses", 64'({state_done, chk_err, busy}), 64'(0));
        check("reset_line", 64'(line), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        rst_auto = 1'b1;
        mon_en = 1;

        // reset while driving the start pulse releases the line on that edge
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        check("start_drives_low", 64'(line), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_line_released", 64'(line), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;

        // no sensor: start pulse length and RELEASE timeout
        exp_q.push_back('{err: 1'b1, data: 40'h0});
        pulse_start();
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (line === 1'b0) n++;
            else break;
        end
        check("start_low_cycles", 64'(n), 64'(40));
        m = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            m++;
            if (chk_err === 1'b1) break;
        end
        check("timeout_cycles", 64'(m), 64'(TMO * D));
        @(negedge clk);
        check("idle_after_timeout", 64'(busy), 64'(0));

        run_frame(40'h37_00_1A_05_56, 0, -1);
        run_frame(40'h37_00_1A_05_57, 0, -1);
        run_frame(40'hA5_5A_F0_0F_FE, 1, -1);

        for (int j = 0; j < 4; j++) begin
            r  = $urandom;
            cs = r[31:24] + r[23:16] + r[15:8] + r[7:0];
            if ($urandom_range(0, 1) == 0) cs = 8'($urandom);
            run_frame({r, cs}, 2, -1);
        end

        // reset in the middle of bit 20
        run_frame(40'h12_34_56_78_14, 2, 20);
        rst = 1'b0;
        @(posedge clk);
        #1 exp_out = '0;
        @(negedge clk);
        check("midrst_outputs", 64'({hum_high, hum_low, tem_high, tem_low, checksum}), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_line", 64'(line), 64'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        run_frame(40'h37_00_1A_05_56, 0, -1);

        for (int k = 0; k < 10000 && !auto_done; k++) @(posedge clk);
        check("auto_done", 64'(auto_done), 64'(1));
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dht11_ctrl.md
Name: dht11_ctrl

Overview:
Single-wire protocol engine for the DHT11 humidity/temperature sensor. It drives the host start pulse, times the sensor response and 40 data bits on the bidirectional line, and verifies the checksum. It publishes five validated bytes plus a one-cycle `state_done` strobe to the downstream bus register block, which converts the bytes to ASCII and latches a ready flag.

Parameters:
- US_DIV, 100, clock cycles per microsecond (100 MHz clk); drives the internal 1 µs tick.
- START_LOW_US, 18000, host start-pulse low time in µs.
- BIT_THRESH_US, 40, data-bit high time strictly greater than this decodes as 1.
- TIMEOUT_US, 200, maximum µs spent in any wait state before abort.
- PERIOD_MS, 2000, auto-trigger interval in ms; 0 disables auto-trigger.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle request for a measurement; ignored unless IDLE
- dht_signal  inout  1  sensor line; driven 0 or released to Z (external pull-up)
- hum_high  out  8  humidity integer byte
- hum_low  out  8  humidity fractional byte
- tem_high  out  8  temperature integer byte
- tem_low  out  8  temperature fractional byte
- checksum  out  8  received checksum byte
- state_done  out  1  one-cycle pulse: new bytes valid
- chk_err  out  1  one-cycle pulse: checksum mismatch or timeout abort
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0 at posedge clk):
  - All five data outputs become 0; state_done, chk_err and busy become 0.
  - FSM goes to IDLE and the line is released.
  - Reset mid-transaction aborts immediately; the line is released on the same edge.
- Input sampling: dht_signal passes through a 2-FF synchronizer. Edge detection uses the synchronized value, giving 2 cycles of input latency.
- Microsecond tick: a counter wraps at US_DIV-1. A shared µs counter clears on each state entry.
- Line drive: dht_signal = 0 only in START; Z in all other states.
- State machine:
  - IDLE: leaves on start=1 or when the period counter expires (PERIOD_MS≠0) -> START.
  - START: drive low for START_LOW_US -> RELEASE.
  - RELEASE: wait for line low (sensor response) -> RESP_L.
  - RESP_L: wait for rising edge -> RESP_H.
  - RESP_H: wait for falling edge -> BIT_L; bit counter = 0.
  - BIT_L: wait for rising edge -> BIT_H.
  - BIT_H: count µs until falling edge.
    - Shift in bit = (count > BIT_THRESH_US), MSB first, into a 40-bit shift register.
    - If bit counter = 39 -> CHECK; else increment the bit counter -> BIT_L.
  - CHECK (1 cycle):
    - If (b39..32 + b31..24 + b23..16 + b15..8) mod 256 == b7..0: load all five output registers and pulse state_done on the next cycle.
    - Otherwise pulse chk_err and leave the outputs unchanged.
    - Then -> IDLE.
- Timeout: in any of RELEASE/RESP_L/RESP_H/BIT_L/BIT_H, µs count reaching TIMEOUT_US -> IDLE with a chk_err pulse; outputs hold the last good values.
- Period counter: runs continuously and reloads when START is entered. start=1 while busy is dropped, not queued.
- Simultaneous start and period expiry: a single transaction results.
- The data outputs change only on the cycle state_done rises and are stable otherwise.

Test Plan:
- Setup: sim with US_DIV=2, START_LOW_US=20, PERIOD_MS=0, a sensor model on a pulled-up line.
- Good frame: start pulse, model sends 0x37,0x00,0x1A,0x05,0x56 -> line low 40 cycles; then hum_high=0x37, hum_low=0x00, tem_high=0x1A, tem_low=0x05, checksum=0x56; state_done high exactly 1 cycle; busy low after.
- Bad checksum: the same frame with last byte 0x57 -> chk_err 1-cycle pulse; no state_done; outputs retain 0x37/0x00/0x1A/0x05/0x56.
- No sensor (line stays high after release): chk_err after TIMEOUT_US·US_DIV cycles in RELEASE; FSM back in IDLE; outputs unchanged.
- Bit threshold: high times of 26 µs and 70 µs decode as 0 and 1; a boundary high time of exactly 40 µs decodes as 0, and 41 µs decodes as 1.
- Reset mid-frame: assert rst=0 at bit 20 -> next edge has line released, busy=0, all outputs 0. A subsequent start with a good frame completes normally.
- Auto-trigger: PERIOD_MS=1 -> START entered every 1000·US_DIV cycles with no start input; start asserted while busy is ignored.
